// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: write-side arbiter in the wclk domain of async_fifo1.
// Shares the FIFO write port among NREQ producers in bursts of up to BURST
// words. The default build uses round-robin order. Define
// WR_ARB_FIXED_PRIO_EN to make the lowest requesting index always win.
module fifo_wr_arbiter #(
  parameter int NREQ  = 4,
  parameter int DSIZE = 8,
  parameter int BURST = 8
) (
  input  logic                    wclk,
  input  logic                    wrst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*DSIZE-1:0]   req_data,
  input  logic                    wfull,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         ack,
  output logic                    winc,
  output logic [DSIZE-1:0]        wdata,
  output logic                    busy
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = (BURST > 0) ? $clog2(BURST + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;

  logic [PTR_W-1:0]  owner_idx;
  logic              owner_req;
  logic [DSIZE-1:0]  owner_data;
  logic              last_word;
  logic              release_now;
  logic [PTR_W-1:0]  base_idle;
  logic [PTR_W-1:0]  base_rel;

  // First requester at or after base, searching upward with wrap-around.
  function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] r,
                                              input logic [PTR_W-1:0] base);
    logic [NREQ-1:0]  g;
    logic             found;
    int               tmp;
    logic [PTR_W-1:0] idx;
    g     = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      tmp = int'(base) + i;
      if (tmp >= NREQ) tmp = tmp - NREQ;
      idx = PTR_W'(tmp);
      if (!found && r[idx]) begin
        g[idx] = 1'b1;
        found  = 1'b1;
      end
    end
    return g;
  endfunction

  // Decode the one-hot owner into an index, its request bit and its word.
  always_comb begin
    owner_idx  = '0;
    owner_req  = 1'b0;
    owner_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_q[i]) begin
        owner_idx  = PTR_W'(i);
        owner_req  = req[i];
        owner_data = req_data[i*DSIZE +: DSIZE];
      end
    end
  end

  // Write port: combinational so the wfull stall takes effect in the same cycle.
  always_comb begin
    winc  = (state_q == GRANT) && owner_req && !wfull && !wrst;
    wdata = winc ? owner_data : '0;
    ack   = winc ? gnt_q : '0;
  end

  assign last_word   = winc && (cnt_q == CNT_LAST);
  assign release_now = (state_q == GRANT) && (!owner_req || last_word);

`ifdef WR_ARB_FIXED_PRIO_EN
  // Lowest index always wins, so every search starts at 0.
  assign base_idle = '0;
  assign base_rel  = '0;
`else
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] next_idx;

  // Index just past the current owner, wrapping at NREQ.
  always_comb begin
    next_idx = (owner_idx == PTR_W'(NREQ - 1)) ? '0 : owner_idx + 1'b1;
    ptr_d    = release_now ? next_idx : ptr_q;
  end

  assign base_idle = ptr_q;
  assign base_rel  = next_idx;

  // Round-robin pointer; moves past the owner whenever it releases.
  always_ff @(posedge wclk) begin
    if (wrst) ptr_q <= '0;
    else      ptr_q <= ptr_d;
  end
`endif

  // Next-state logic: grant from IDLE, or hand over without a bubble on release.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d   = rr_pick(req, base_idle);
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (release_now) begin
          gnt_d = rr_pick(req, base_rel);
          cnt_d = '0;
          state_d = (|gnt_d) ? GRANT : IDLE;
        end else if (winc) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        cnt_d   = '0;
      end
    endcase
    busy_d = |gnt_d;
  end

  // FSM state and registered outputs.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt  = gnt_q;
  assign busy = busy_q;

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Write-side arbiter in the `wclk` domain of `async_fifo1`. It shares the FIFO write port (`winc`/`wdata`, backpressured by `wfull`) among `NREQ` producers. Access is granted in round-robin order, in bursts of up to `BURST` words, so no producer can monopolise the FIFO. The block is purely synchronous to `wclk`; the read side of the FIFO is untouched.

## Interface
- `NREQ`, default 4: number of producers; legal values are ≥2.
- `DSIZE`, default 8: data width; must match the FIFO's `DSIZE`.
- `BURST`, default 8: maximum words accepted per grant; legal values are ≥1.

- `wclk`  in  1  write-domain clock; all state updates on the rising edge.
- `wrst`  in  1  reset, synchronous and active-high.
- `req`  in  NREQ  per-producer request/valid; the producer holds its word on `req_data` while high.
- `req_data`  in  NREQ*DSIZE  producer words; producer i occupies bits [i*DSIZE +: DSIZE].
- `wfull`  in  1  FIFO full flag, already in the `wclk` domain.
- `gnt`  out  NREQ  registered one-hot owner; all zero when idle.
- `ack`  out  NREQ  combinational; one-hot pulse meaning the owner's word is written this cycle.
- `winc`  out  1  combinational FIFO write enable.
- `wdata`  out  DSIZE  combinational FIFO write data.
- `busy`  out  1  registered; high while any grant is held.

## Operation
- The FSM has two states, IDLE and GRANT. Registers: `owner` (one-hot), `ptr` (clog2(NREQ) bits), and `cnt` (clog2(BURST+1) bits).
- **IDLE:**
  - If any `req` bit is high, at the next edge select the first requester at or after `ptr`, searching upward with wrap-around.
  - On that edge: `gnt` = that requester, `cnt` = 0, and the FSM goes to GRANT.
- **GRANT, write:**
  - `winc` = `req[owner] & !wfull`.
  - `wdata` = the owner's slice of `req_data` when `winc` is high, else 0.
  - `ack[owner]` = `winc`.
  - Each write increments `cnt`.
- **Release condition:** any of the following.
  - `req[owner]` is low.
  - A write occurs with `cnt == BURST-1`, meaning this is the final word of the burst.
- **On release:**
  - `ptr` = (owner index + 1) mod NREQ.
  - At the same edge, re-arbitrate from the new `ptr` against the current `req`, with no bubble cycle.
  - If another requester is selected, stay in GRANT with `cnt` = 0.
  - If nothing is selected, go to IDLE and drive `gnt` = 0.
  - The released owner is re-granted only if it is the sole requester.
- **wfull stall:** `winc` is held at 0, `cnt` is frozen and the grant is held. Stall cycles do not count toward `BURST`.
- **Dropped requests:** `req` bits of non-owners may drop at any time with no effect.
- **Reset:**
  - State = IDLE, `gnt` = 0, `ptr` = 0, `cnt` = 0, `busy` = 0.
  - As a result, `winc` = 0, `ack` = 0 and `wdata` = 0.
  - Asserting `wrst` mid-burst aborts the burst at that edge. No write occurs in a cycle where `wrst` is high, because `winc` is gated by `!wrst`.

## Timing
- **Grant latency:** `req` is seen high at edge k, `gnt` is valid after edge k, and the first write can occur in cycle k+1.
- **Throughput:** one word per cycle while the owner holds `req` and `wfull` is low. Ownership changes between bursts add no idle cycle.
- **Producer handshake:** the producer samples `ack` at the rising edge and presents its next word or drops `req` in the following cycle.
- **FIFO sampling:** `winc`, `wdata` and `wfull` are all sampled by the FIFO at the same edge. The `wfull → winc` path is combinational; no write is ever issued while `wfull` is high.
- **BURST=1:** re-arbitration happens after every word.

## Configuration
- The macro is `WR_ARB_FIXED_PRIO_EN`.
- **Not defined (default):** round-robin arbitration as described above.
- **Defined:**
  - Every arbitration searches from index 0, so the lowest index wins.
  - `ptr` is not implemented.
  - `BURST` limiting still applies. At burst end the lowest pending index, including the current owner, wins.

## Test plan
- **Reset check:** hold `wrst` high for 3 cycles with all `req` high → `gnt`=0, `winc`=0, `busy`=0 throughout; the first `gnt`=0001 appears one edge after `wrst` falls.
- **Round-robin (default build):** NREQ=4, BURST=4, all `req` held high with unique per-requester data, `wfull`=0 → 16 consecutive writes in order 4×r0, 4×r1, 4×r2, 4×r3, with no idle cycle, and each `ack` aligned to its word.
- **wfull stall:** force `wfull`=1 for 5 cycles in the middle of r1's burst → `winc`=0 for those 5 cycles, `gnt` stays 0010, and r1 still delivers exactly 4 words in total.
- **Early release:** r2 drops `req` after 2 words → the grant moves to r3 at the next edge and `ptr` advances past r2.
- **Fixed priority (`WR_ARB_FIXED_PRIO_EN` defined):** r0 and r3 request continuously → only r0 is written, and r3 gets no `ack`. Then drop r0 → r3 is granted on the next edge.
- **End-to-end:** drive the arbiter into `async_fifo1` (ASIZE=9) with 1024 random words from 4 producers. Check a per-producer FIFO model on the read side → 1024 passes, 0 failures.
